// File: rtl/split_assign_driver.sv
// Assembles a word stream into a flat assignment bus, holds it for a split checker
// to evaluate, and returns the sampled verdict over a valid/ready handshake.
module split_assign_driver #(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned TOTAL_BITS = 1500,
    parameter int unsigned CHK_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_W-1:0]     in_data,
    input  logic                  in_last,
    output logic [TOTAL_BITS-1:0] assign_bus,
    output logic                  assign_valid,
    input  logic                  chk_x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sat,
    output logic                  out_err,
    output logic [15:0]           sat_cnt
);

    localparam int unsigned NUM_WORDS = (TOTAL_BITS + WORD_W - 1) / WORD_W;
    localparam int unsigned IDX_W     = $clog2(NUM_WORDS + 1);
    localparam int unsigned LAT_W     = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;
    localparam int unsigned CNT_W     = 16;

    typedef enum logic [1:0] {
        S_LOAD,
        S_EVAL,
        S_REPORT
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_in_ready;
    logic                    r_assign_valid;
    logic                    r_out_valid;
    logic                    r_out_sat;
    logic                    r_out_err;
    logic [CNT_W-1:0]        r_sat_cnt;
    logic [TOTAL_BITS-1:0]   r_bus;
    logic [TOTAL_BITS-1:0]   w_bus_nxt;
    logic [IDX_W-1:0]        r_widx;
    logic                    r_ovf;
    logic [LAT_W-1:0]        r_lat;

    logic                    w_acc;
    logic                    w_wr;
    logic                    w_hs;
    logic                    w_lat_done;
    logic                    w_len_ok;
    logic                    w_len_err;

    // in_ready is only ever high in LOAD, so acceptance needs no extra state qualifier
    assign w_acc      = in_valid && r_in_ready;
    assign w_wr       = w_acc && (r_widx < IDX_W'(NUM_WORDS));
    assign w_hs       = r_out_valid && out_ready;
    assign w_lat_done = (r_state == S_EVAL) && (r_lat == LAT_W'(CHK_LAT - 1));
    assign w_len_ok   = (r_widx == IDX_W'(NUM_WORDS - 1)) && !r_ovf;
    assign w_len_err  = (r_state == S_LOAD) && w_acc && in_last && !w_len_ok;

    // Per-word write lanes; the last lane is narrowed so bits past TOTAL_BITS are dropped
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
        localparam int unsigned LO = WORD_W * gi;
        localparam int unsigned SW = ((TOTAL_BITS - LO) < WORD_W) ? (TOTAL_BITS - LO) : WORD_W;
        assign w_bus_nxt[LO +: SW] = (w_wr && (r_widx == IDX_W'(gi))) ? in_data[SW-1:0]
                                                                       : r_bus[LO +: SW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD: begin
                if (w_acc && in_last) begin
                    w_state_nxt = w_len_ok ? S_EVAL : S_REPORT;
                end
            end
            S_EVAL: begin
                if (w_lat_done) begin
                    w_state_nxt = S_REPORT;
                end
            end
            S_REPORT: begin
                if (w_hs) begin
                    w_state_nxt = S_LOAD;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Handshake flags track the upcoming state so they line up with it cycle-for-cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready     <= 1'b0;
            r_assign_valid <= 1'b0;
            r_out_valid    <= 1'b0;
        end else begin
            r_in_ready     <= (w_state_nxt == S_LOAD);
            r_assign_valid <= (w_state_nxt == S_EVAL);
            r_out_valid    <= (w_state_nxt == S_REPORT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus  <= '0;
            r_widx <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_bus <= w_bus_nxt;
            if (w_hs) begin
                r_widx <= '0;
                r_ovf  <= 1'b0;
            end else if (w_wr) begin
                r_widx <= r_widx + IDX_W'(1);
            end else if (w_acc) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat <= '0;
        end else if ((r_state == S_EVAL) && !w_lat_done) begin
            r_lat <= r_lat + LAT_W'(1);
        end else begin
            r_lat <= '0;
        end
    end

    // Verdict capture: chk_x only matters in the final evaluation cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_sat <= 1'b0;
            r_out_err <= 1'b0;
        end else if (w_len_err) begin
            r_out_sat <= 1'b0;
            r_out_err <= 1'b1;
        end else if (w_lat_done) begin
            r_out_sat <= chk_x;
            r_out_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (w_hs && r_out_sat && (r_sat_cnt != {CNT_W{1'b1}})) begin
            r_sat_cnt <= r_sat_cnt + CNT_W'(1);
        end
    end

    assign in_ready     = r_in_ready;
    assign assign_bus   = r_bus;
    assign assign_valid = r_assign_valid;
    assign out_valid    = r_out_valid;
    assign out_sat      = r_out_sat;
    assign out_err      = r_out_err;
    assign sat_cnt      = r_sat_cnt;

endmodule

// File: tb/tb_split_assign_driver.sv
// Directed plus randomized bench for split_assign_driver against a transaction-level model.
module tb_split_assign_driver;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned TOTAL_BITS = 70;
    localparam int unsigned CHK_LAT    = 2;
    localparam int unsigned NUM_WORDS  = 3;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_W-1:0]     in_data;
    logic                  in_last;
    logic [TOTAL_BITS-1:0] assign_bus;
    logic                  assign_valid;
    logic                  chk_x;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_sat;
    logic                  out_err;
    logic [15:0]           sat_cnt;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: expected bus contents and SAT count
    logic [TOTAL_BITS-1:0] m_bus = '0;
    logic [15:0]           m_cnt = '0;
    logic [31:0]           wq[$];

    split_assign_driver #(
        .WORD_W    (WORD_W),
        .TOTAL_BITS(TOTAL_BITS),
        .CHK_LAT   (CHK_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .assign_bus  (assign_bus),
        .assign_valid(assign_valid),
        .chk_x       (chk_x),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sat     (out_sat),
        .out_err     (out_err),
        .sat_cnt     (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, 96'(in_ready), 96'(0));
        chk({tag, "_bus"}, 96'(assign_bus), 96'(0));
        chk({tag, "_assign_valid"}, 96'(assign_valid), 96'(0));
        chk({tag, "_out_valid"}, 96'(out_valid), 96'(0));
        chk({tag, "_out_sat"}, 96'(out_sat), 96'(0));
        chk({tag, "_out_err"}, 96'(out_err), 96'(0));
        chk({tag, "_sat_cnt"}, 96'(sat_cnt), 96'(0));
    endtask

    // Send wq as one assignment, check timing and verdict, then complete the handshake
    task automatic run(input logic c, input int rdelay, input bit do_rst);
        int          n;
        int          waitc;
        bit          err;
        logic        exp_sat;
        logic [95:0] pad;
        n     = wq.size();
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("in_ready_wait", 96'(in_ready), 96'(1));
        err = (n != NUM_WORDS);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = wq[i];
            in_last  = (i == n - 1);
            chk_x    = ~c;
            if (i < NUM_WORDS) begin
                pad = 96'(m_bus);
                pad[i*32 +: 32] = wq[i];
                m_bus = pad[TOTAL_BITS-1:0];
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (err) begin
            chk("err_out_valid", 96'(out_valid), 96'(1));
            chk("err_assign_valid", 96'(assign_valid), 96'(0));
            chk("err_out_err", 96'(out_err), 96'(1));
            chk("err_out_sat", 96'(out_sat), 96'(0));
        end else begin
            for (int k = 0; k < CHK_LAT; k++) begin
                chk("eval_assign_valid", 96'(assign_valid), 96'(1));
                chk("eval_out_valid", 96'(out_valid), 96'(0));
                chk("eval_in_ready", 96'(in_ready), 96'(0));
                if (do_rst && k == 0) begin
                    #2 rst_n = 1'b0;
                    #1;
                    m_bus = '0;
                    m_cnt = '0;
                    chk_all_zero("rst_eval");
                    repeat (3) begin
                        @(negedge clk);
                        chk("rst_hold_out_valid", 96'(out_valid), 96'(0));
                    end
                    rst_n = 1'b1;
                    chk("rst_rel_in_ready", 96'(in_ready), 96'(0));
                    @(negedge clk);
                    chk("rst_rel_in_ready_rise", 96'(in_ready), 96'(1));
                    chk("rst_rel_out_valid", 96'(out_valid), 96'(0));
                    return;
                end
                chk_x = (k == CHK_LAT - 1) ? c : ~c;
                @(negedge clk);
            end
            chk("rep_out_valid", 96'(out_valid), 96'(1));
            chk("rep_assign_valid", 96'(assign_valid), 96'(0));
            chk("rep_out_sat", 96'(out_sat), 96'(c));
            chk("rep_out_err", 96'(out_err), 96'(0));
        end
        chk("rep_bus", 96'(assign_bus), 96'(m_bus));
        exp_sat = !err && c;
        chk_x   = ~c;
        repeat (rdelay) begin
            @(negedge clk);
            chk("bp_out_valid", 96'(out_valid), 96'(1));
            chk("bp_out_sat", 96'(out_sat), 96'(exp_sat));
            chk("bp_in_ready", 96'(in_ready), 96'(0));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (exp_sat && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        chk("hs_out_valid", 96'(out_valid), 96'(0));
        chk("hs_in_ready", 96'(in_ready), 96'(1));
        chk("hs_sat_cnt", 96'(sat_cnt), 96'(m_cnt));
    endtask

    task automatic rand_words(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back($urandom);
    endtask

    initial begin
        int r;
        int n;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        chk_x     = 1'b0;
        out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_in_ready", 96'(in_ready), 96'(0));
        @(negedge clk);
        chk("first_in_ready", 96'(in_ready), 96'(1));

        // Basic SAT with the documented words
        wq = '{32'hDEADBEEF, 32'h12345678, 32'h0000003F};
        run(1'b1, 0, 1'b0);
        chk("s1_bus_const", 96'(assign_bus), 96'(70'h3F_12345678_DEADBEEF));
        chk("s1_sat_cnt", 96'(sat_cnt), 96'(1));

        // UNSAT with five cycles of backpressure
        rand_words(3);
        run(1'b0, 5, 1'b0);
        chk("s2_sat_cnt", 96'(sat_cnt), 96'(1));

        // Short and long assignments
        rand_words(2);
        run(1'b1, 1, 1'b0);
        rand_words(5);
        run(1'b1, 0, 1'b0);

        // Randomized mix of lengths, verdicts and backpressure
        for (int t = 0; t < 24; t++) begin
            r = $urandom_range(0, 3);
            n = (r == 0) ? $urandom_range(1, 5) : 3;
            rand_words(n);
            run(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end

        // Reset during EVAL, then a normal load
        rand_words(3);
        run(1'b1, 0, 1'b1);
        rand_words(3);
        run(1'b1, 2, 1'b0);
        chk("s5_sat_cnt", 96'(sat_cnt), 96'(1));

        // Saturation of the SAT counter
        @(negedge clk);
        force dut.r_sat_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.r_sat_cnt;
        m_cnt = 16'hFFFE;
        chk("s6_preload", 96'(sat_cnt), 96'(16'hFFFE));
        rand_words(3);
        run(1'b1, 0, 1'b0);
        rand_words(3);
        run(1'b1, 0, 1'b0);
        chk("s6_saturated", 96'(sat_cnt), 96'(16'hFFFF));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
